// File: rtl/clk_toggle_gen.sv
// clk_toggle_gen: three independent programmable heartbeat dividers of the board
// clock, frozen and resumed together by a debounced active-low pause button.
module clk_toggle_gen #(
  parameter int unsigned HALF0     = 25_000_000,
  parameter int unsigned HALF1     = 12_500_000,
  parameter int unsigned HALF2     = 6_250_000,
  parameter int unsigned CW        = 25,
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned DBW       = 20
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       key_n,
  output logic [2:0] clk_toggle,
  output logic       paused
);

  localparam int unsigned NCH = 3;

  // Terminal counts, one per channel; HALFi-1 always fits in CW bits.
  localparam logic [NCH-1:0][CW-1:0] TC = {CW'(HALF2 - 1), CW'(HALF1 - 1), CW'(HALF0 - 1)};
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic           w_paused_next;
  logic           r_paused;

  logic           r_sync1;
  logic           r_sync2;
  logic           r_db_level;
  logic [DBW-1:0] r_db_cnt;
  logic           r_press;

  logic [CW-1:0]  r_cnt [NCH];
  logic [NCH-1:0] r_tog;
  logic           w_run;

  assign clk_toggle = r_tog;
  assign paused     = r_paused;
  assign w_run      = (r_state == ST_RUN);

  // Two-flop synchroniser for the asynchronous button; idles released (1).
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: accept a new level after DB_CYCLES consecutive differing samples;
  // a falling acceptance emits a one-cycle registered press pulse.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_db_level <= 1'b1;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
        r_press    <= ~r_sync2;
      end else begin
        r_db_cnt <= r_db_cnt + DBW'(1);
      end
    end
  end

  // Run/pause state register; paused is registered alongside the state.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_paused <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_paused <= w_paused_next;
    end
  end

  // Every press event flips between RUN and PAUSE.
  always_comb begin
    w_state_next  = r_state;
    w_paused_next = 1'b0;
    case (r_state)
      ST_RUN:   if (r_press) w_state_next = ST_PAUSE;
      ST_PAUSE: if (r_press) w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
    w_paused_next = (w_state_next == ST_PAUSE);
  end

  // Dividers advance only while RUN was in effect before the edge, so an edge
  // that enters PAUSE still completes its own count/toggle.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
      r_tog <= '0;
    end else if (w_run) begin
      for (int i = 0; i < NCH; i++) begin
        if (r_cnt[i] == TC[i]) begin
          r_cnt[i] <= '0;
          r_tog[i] <= ~r_tog[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule
